// File: rtl/lcd_display_arbiter.sv
// Round-robin arbiter sharing one LCD1602 controller between the people counter (A)
// and the threshold/alarm value (B); each granted value is held for HOLD_CYCLES cycles.
module lcd_display_arbiter #(
    parameter int WIDTH       = 7,
    parameter int HOLD_CYCLES = 150000,
    parameter int CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic [WIDTH-1:0] val_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] val_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [WIDTH-1:0] lcd_in,
    output logic             lcd_ready,
    output logic             busy,
    output logic             active_src
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t           state_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic             prio_r;      // 0: A wins a tie, 1: B wins a tie
    logic             winner_r;
    logic             pick_b_s;

    // Choose the source to serve from the live requests and the round-robin pointer.
    always_comb begin
        pick_b_s = 1'b0;
        if (req_a && req_b) begin
            pick_b_s = prio_r;
        end else if (req_b) begin
            pick_b_s = 1'b1;
        end else begin
            pick_b_s = 1'b0;
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= CNT_ZERO;
            prio_r     <= 1'b0;
            winner_r   <= 1'b0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            lcd_in     <= {WIDTH{1'b0}};
            lcd_ready  <= 1'b0;
            busy       <= 1'b0;
            active_src <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        state_r  <= ST_GRANT;
                        winner_r <= pick_b_s;
                        gnt_a    <= ~pick_b_s;
                        gnt_b    <= pick_b_s;
                        busy     <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // The value is captured at the end of the grant cycle, not at the request.
                    gnt_a      <= 1'b0;
                    gnt_b      <= 1'b0;
                    lcd_in     <= winner_r ? val_b : val_a;
                    active_src <= winner_r;
                    lcd_ready  <= 1'b1;
                    prio_r     <= ~winner_r;
                    hold_cnt_r <= HOLD_LOAD;
                    state_r    <= ST_HOLD;
                end
                ST_HOLD: begin
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    if (hold_cnt_r == CNT_ZERO) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_a   <= 1'b0;
                    gnt_b   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_display_arbiter.sv
// Self-checking bench for lcd_display_arbiter with HOLD_CYCLES=10 and a 20 ns clock;
// expected outputs come from a grant-timeline model driven by the same inputs.
module tb_lcd_display_arbiter;

    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [6:0] val_a, val_b;
    logic       gnt_a, gnt_b, lcd_ready, busy, active_src;
    logic [6:0] lcd_in;
    logic [11:0] act_vec;

    int checks   = 0;
    int failures = 0;

    // reference model: a grant at edge k owns the display until edge k+HOLD+2
    int         e = 0;
    int         g_edge;
    int         avail;
    logic       g_src, m_ptr, m_ready, m_src;
    logic [6:0] m_lcd;
    logic       exp_gnt_a, exp_gnt_b, exp_busy;

    lcd_display_arbiter #(.WIDTH(7), .HOLD_CYCLES(HOLD), .CNT_W(24)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .val_a(val_a), .req_b(req_b), .val_b(val_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .lcd_in(lcd_in), .lcd_ready(lcd_ready),
        .busy(busy), .active_src(active_src)
    );

    assign act_vec = {gnt_a, gnt_b, busy, lcd_ready, active_src, lcd_in};

    always #10 clk = ~clk;

    function automatic logic [11:0] exp_vec();
        return {exp_gnt_a, exp_gnt_b, exp_busy, m_ready, m_src, m_lcd};
    endfunction

    task automatic m_reset();
        g_edge = -100000; avail = -100000;
        g_src = 1'b0; m_ptr = 1'b0; m_ready = 1'b0; m_src = 1'b0; m_lcd = 7'd0;
        exp_gnt_a = 1'b0; exp_gnt_b = 1'b0; exp_busy = 1'b0;
    endtask

    // Advance the model by one edge using the inputs present at that edge.
    task automatic model_step();
        logic w;
        e = e + 1;
        if (e == g_edge + 1) begin
            m_lcd   = g_src ? val_b : val_a;
            m_ready = 1'b1;
            m_src   = g_src;
        end
        if (e >= avail && (req_a || req_b)) begin
            w      = (req_a && req_b) ? m_ptr : req_b;
            g_edge = e;
            g_src  = w;
            m_ptr  = ~w;
            avail  = e + HOLD + 2;
        end
        exp_gnt_a = (g_edge == e) && !g_src;
        exp_gnt_b = (g_edge == e) && g_src;
        exp_busy  = (e >= g_edge) && (e <= g_edge + HOLD);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int gnt_cnt = 0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        checks++;
        if (act_vec !== 12'd0) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", act_vec, 12'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            gnt_cnt += int'(gnt_a) + int'(gnt_b);
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
        end
        checks++;
        if (lcd_ready !== 1'b0 || lcd_in !== 7'd0 || busy !== 1'b0 || gnt_cnt != 0) begin
            failures++;
            $display("FAIL reset_idle_state: ready=%b lcd=%0d busy=%b gnts=%0d expected 0/0/0/0",
                     lcd_ready, lcd_in, busy, gnt_cnt);
        end
    endtask

    task automatic test_single_a();
        int first_gnt = -1, first_lcd = -1, busy_cnt = 0;
        req_a = 1'b1; val_a = 7'd123;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL single_a: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (gnt_a === 1'b1 && first_gnt < 0) first_gnt = i;
            if (lcd_in === 7'd123 && first_lcd < 0) first_lcd = i;
            if (busy === 1'b1) busy_cnt++;
            if (exp_gnt_a) req_a = 1'b0;
        end
        checks++;
        if (first_gnt != 1 || first_lcd != 2 || busy_cnt != 11) begin
            failures++;
            $display("FAIL single_a_timing: gnt@%0d lcd@%0d busy=%0d expected 1/2/11",
                     first_gnt, first_lcd, busy_cnt);
        end
        checks++;
        if (lcd_ready !== 1'b1 || active_src !== 1'b0) begin
            failures++;
            $display("FAIL single_a_flags: ready=%b src=%b expected 1/0", lcd_ready, active_src);
        end
    endtask

    task automatic test_both_and_val_change();
        int ga = -1, gb = -1;
        logic [6:0] seq[$];
        logic [6:0] prev;
        reset = 1'b0;
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b1; req_b = 1'b1; val_a = 7'd7; val_b = 7'd100;
        prev = 7'd0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL both_req: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (gnt_a === 1'b1) ga = i;
            if (gnt_b === 1'b1) gb = i;
            if (lcd_in !== prev) begin
                seq.push_back(lcd_in);
                prev = lcd_in;
            end
            if (exp_gnt_a) req_a = 1'b0;
            if (exp_gnt_b) req_b = 1'b0;
            if (i == 5) val_a = 7'd55;
        end
        checks++;
        if (ga != 1 || gb != 13) begin
            failures++;
            $display("FAIL both_order: gnt_a@%0d gnt_b@%0d expected 1/13", ga, gb);
        end
        checks++;
        if (seq.size() != 2 || seq[0] !== 7'd7 || seq[1] !== 7'd100) begin
            failures++;
            $display("FAIL lcd_sequence: count=%0d first=%0d expected 2 values 7,100",
                     seq.size(), (seq.size() > 0) ? seq[0] : 7'd0);
        end
    endtask

    task automatic test_back_to_back();
        int   t_q[$];
        logic s_q[$];
        req_a = 1'b1; req_b = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL back_to_back: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
                t_q.push_back(i);
                s_q.push_back(gnt_b);
            end
            if (i == 2) begin
                checks++;
                if (lcd_in !== 7'd55) begin
                    failures++;
                    $display("FAIL regrant_value: got %0d expected 55", lcd_in);
                end
            end
        end
        checks++;
        if (t_q.size() != 5 || s_q[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: grants=%0d first_src=%b expected 5/0",
                     t_q.size(), (s_q.size() > 0) ? s_q[0] : 1'b1);
        end
        for (int i = 1; i < t_q.size(); i++) begin
            checks++;
            if (s_q[i] === s_q[i-1] || t_q[i] - t_q[i-1] != 12) begin
                failures++;
                $display("FAIL b2b_alternate: grant %0d src=%b gap=%0d expected other src, gap 12",
                         i, s_q[i], t_q[i] - t_q[i-1]);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 14; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (exp_gnt_a) req_a = 1'b0;
            else if (!req_a) req_a = ($urandom_range(3, 0) == 0);
            else if ($urandom_range(19, 0) == 0) req_a = 1'b0;
            if (exp_gnt_b) req_b = 1'b0;
            else if (!req_b) req_b = ($urandom_range(3, 0) == 0);
            else if ($urandom_range(19, 0) == 0) req_b = 1'b0;
            if ($urandom_range(2, 0) == 0) val_a = 7'($urandom);
            if ($urandom_range(2, 0) == 0) val_b = 7'($urandom);
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_drain: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int gb = -1;
        req_a = 1'b1; val_a = 7'd99;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL pre_reset: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (exp_gnt_a) req_a = 1'b0;
        end
        #5;
        reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (act_vec !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_hold: got %h expected %h", act_vec, 12'd0);
        end
        @(negedge clk);
        req_b = 1'b1; val_b = 7'd42;
        reset = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                failures++;
                $display("FAIL post_reset: cycle %0d got %h expected %h", i, act_vec, exp_vec());
            end
            if (gnt_b === 1'b1 && gb < 0) gb = i;
            if (exp_gnt_b) req_b = 1'b0;
        end
        checks++;
        if (gb != 1 || lcd_in !== 7'd42 || active_src !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_b: gnt_b@%0d lcd=%0d src=%b expected 1/42/1",
                     gb, lcd_in, active_src);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        val_a = 7'd0; val_b = 7'd0;
        m_reset();
        test_reset();
        test_single_a();
        test_both_and_val_change();
        test_back_to_back();
        test_random();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
